// File: rtl/axi_chan_multicut.sv
// axi_chan_multicut: NoCuts valid/ready register slices in series for one AXI channel.
// Latency NoCuts edges; FullBw slices are 2-entry skids (1 beat/cycle), else 1-entry (1 beat/2 cycles); slv_ready_o drops at capacity.
module axi_chan_multicut #(
  parameter int unsigned  DataWidth = 32,
  parameter int unsigned  NoCuts    = 1,
  parameter bit           FullBw    = 1'b1,
  localparam int unsigned Cap       = (FullBw ? 2 : 1) * NoCuts,
  localparam int unsigned OccW      = (Cap > 0) ? $clog2(Cap + 1) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 slv_valid_i,
  output logic                 slv_ready_o,
  input  logic [DataWidth-1:0] slv_data_i,
  output logic                 mst_valid_o,
  input  logic                 mst_ready_i,
  output logic [DataWidth-1:0] mst_data_o,
  output logic [OccW-1:0]      occ_o
);

  if (NoCuts == 0) begin : g_wire
    assign mst_valid_o = slv_valid_i;
    assign slv_ready_o = mst_ready_i;
    assign mst_data_o  = slv_data_i;
    assign occ_o       = '0;
  end else begin : g_chain
    // Index i is the input side of slice i; index NoCuts is the master port.
    logic                 vld [NoCuts+1];
    logic                 rdy [NoCuts+1];
    logic [DataWidth-1:0] dat [NoCuts+1];
    logic [OccW-1:0]      occ_q;
    logic                 up;
    logic                 dn;

    assign vld[0]      = slv_valid_i;
    assign dat[0]      = slv_data_i;
    assign slv_ready_o = rdy[0];
    assign mst_valid_o = vld[NoCuts];
    assign mst_data_o  = dat[NoCuts];
    assign rdy[NoCuts] = mst_ready_i;

    for (genvar i = 0; i < NoCuts; i++) begin : g_cut
      if (FullBw) begin : g_skid
        logic                 valid_q;
        logic                 full_q;
        logic                 push;
        logic                 pop;
        logic [DataWidth-1:0] d0_q;
        logic [DataWidth-1:0] d1_q;

        // d0_q always holds the older beat; d1_q is only live while full_q.
        assign push     = vld[i] & ~full_q;
        assign pop      = valid_q & rdy[i+1];
        assign rdy[i]   = ~full_q;
        assign vld[i+1] = valid_q;
        assign dat[i+1] = d0_q;

        always_ff @(posedge clk_i) begin
          if (!rst_ni) begin
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            d0_q    <= '0;
            d1_q    <= '0;
          end else if (push && pop) begin
            d0_q <= dat[i];
          end else if (push) begin
            if (valid_q) begin
              d1_q   <= dat[i];
              full_q <= 1'b1;
            end else begin
              d0_q    <= dat[i];
              valid_q <= 1'b1;
            end
          end else if (pop) begin
            if (full_q) begin
              d0_q   <= d1_q;
              full_q <= 1'b0;
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
      end else begin : g_half
        logic                 full_q;
        logic [DataWidth-1:0] d_q;

        assign rdy[i]   = ~full_q;
        assign vld[i+1] = full_q;
        assign dat[i+1] = d_q;

        // Ready is ~full_q, so a push can never coincide with a pop.
        always_ff @(posedge clk_i) begin
          if (!rst_ni) begin
            full_q <= 1'b0;
            d_q    <= '0;
          end else if (full_q) begin
            if (rdy[i+1]) full_q <= 1'b0;
          end else if (vld[i]) begin
            full_q <= 1'b1;
            d_q    <= dat[i];
          end
        end
      end
    end

    assign up = slv_valid_i & rdy[0];
    assign dn = vld[NoCuts] & mst_ready_i;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        occ_q <= '0;
      end else if (up && !dn) begin
        occ_q <= occ_q + OccW'(1);
      end else if (dn && !up) begin
        occ_q <= occ_q - OccW'(1);
      end
    end

    assign occ_o = occ_q;

    a_occ_cap: assert property (@(posedge clk_i) disable iff (!rst_ni) occ_q <= OccW'(Cap));
    a_mst_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (mst_valid_o && !mst_ready_i) |=> (mst_valid_o && $stable(mst_data_o)));
  end

endmodule
